// File: rtl/cache_burst_if.sv
// cache_burst_if: CPU request, tag/data array control and memory burst signals
// of cache_burst_ctrl; master is the controller side, slave the environment.
interface cache_burst_if #(
    parameter int WAYS  = 4,
    parameter int BEATS = 8
);
    localparam int WW = $clog2(WAYS);
    localparam int BW = $clog2(BEATS);
    logic            cpu_valid, cpu_rw, cpu_ready, resp_valid, hit_miss;
    logic [WAYS-1:0] match_way, valid_way, dirty_way;
    logic [WW-1:0]   lru_victim, way_sel;
    logic [BW-1:0]   beat_idx;
    logic            tag_we, data_we, dirty_set, dirty_clr, lru_touch;
    logic            mem_avalid, mem_aready, mem_rw;
    logic            mem_wvalid, mem_wready, mem_wlast;
    logic            mem_rvalid, mem_rready, mem_rlast;
    logic            err;

    modport master (
        input  cpu_valid, cpu_rw, match_way, valid_way, dirty_way, lru_victim,
        input  mem_aready, mem_wready, mem_rvalid, mem_rlast,
        output cpu_ready, resp_valid, hit_miss, way_sel, beat_idx,
        output tag_we, data_we, dirty_set, dirty_clr, lru_touch,
        output mem_avalid, mem_rw, mem_wvalid, mem_wlast, mem_rready, err
    );

    modport slave (
        output cpu_valid, cpu_rw, match_way, valid_way, dirty_way, lru_victim,
        output mem_aready, mem_wready, mem_rvalid, mem_rlast,
        input  cpu_ready, resp_valid, hit_miss, way_sel, beat_idx,
        input  tag_we, data_we, dirty_set, dirty_clr, lru_touch,
        input  mem_avalid, mem_rw, mem_wvalid, mem_wlast, mem_rready, err
    );
endinterface

// File: rtl/cache_burst_ctrl.sv
// cache_burst_ctrl: N-way cache controller with dirty writeback and BEATS-word refill bursts.
// Defining CACHE_PERF_CNT_EN adds saturating hit_cnt/miss_cnt outputs of width CNT_W.
module cache_burst_ctrl #(
    parameter int WAYS  = 4,
    parameter int BEATS = 8
`ifdef CACHE_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input logic clk,
    input logic rst,
    cache_burst_if.master bus
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
`endif
);
    localparam int WW = $clog2(WAYS);
    localparam int BW = $clog2(BEATS);
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, WB_ADDR, WB_DATA, LD_ADDR, LD_DATA, DONE} state_t;

    state_t        state, next;
    logic [BW-1:0] cnt;
    logic [WW-1:0] victim, hit_way;
    logic          req_hit, req_miss, last, victim_dirty, addr_phase, wacc, racc, ack;

    always_comb begin
        hit_way = '0;
        for (int i = 0; i < WAYS; i++)
            if (bus.match_way[i]) hit_way = hit_way | WW'(i);
    end

    assign req_hit      = state == LOOKUP && bus.cpu_valid && |bus.match_way;
    assign req_miss     = state == LOOKUP && bus.cpu_valid && !(|bus.match_way);
    assign last         = cnt == LAST;
    assign victim_dirty = bus.valid_way[bus.lru_victim] & bus.dirty_way[bus.lru_victim];
    assign addr_phase   = state == WB_ADDR || state == LD_ADDR;
    assign wacc         = state == WB_DATA && bus.mem_wready;
    assign racc         = state == LD_DATA && bus.mem_rvalid;
    assign ack          = req_hit || state == DONE;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            victim <= '0;
        end else begin
            if (req_miss) victim <= bus.lru_victim;
            if (addr_phase) cnt <= '0;
            else if (wacc || racc) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = LOOKUP;
            LOOKUP:  if (req_miss) next = victim_dirty ? WB_ADDR : LD_ADDR;
            WB_ADDR: if (bus.mem_aready) next = WB_DATA;
            WB_DATA: if (wacc && last) next = LD_ADDR;
            LD_ADDR: if (bus.mem_aready) next = LD_DATA;
            LD_DATA: if (racc && last) next = DONE;
            DONE:    next = LOOKUP;
            default: next = IDLE;
        endcase
    end

    // The miss cycle already addresses the LRU way; later phases use the latched copy.
    always_comb begin
        bus.cpu_ready  = ack;
        bus.hit_miss   = req_hit;
        bus.resp_valid = ack && !bus.cpu_rw;
        bus.lru_touch  = ack;
        bus.dirty_set  = ack && bus.cpu_rw;
        bus.data_we    = (ack && bus.cpu_rw) || racc;
        bus.tag_we     = racc && last;
        bus.dirty_clr  = wacc && last;
        bus.way_sel    = req_hit ? hit_way : state == LOOKUP ? bus.lru_victim : victim;
        bus.beat_idx   = (state == WB_DATA || state == LD_DATA) ? cnt : '0;
        bus.mem_avalid = addr_phase;
        bus.mem_rw     = state == WB_ADDR;
        bus.mem_wvalid = state == WB_DATA;
        bus.mem_wlast  = state == WB_DATA && last;
        bus.mem_rready = state == LD_DATA;
        bus.err        = racc && (bus.mem_rlast != last);
    end

`ifdef CACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (req_hit && !(&hit_cnt)) hit_cnt <= hit_cnt + 1'b1;
            if (req_miss && !(&miss_cnt)) miss_cnt <= miss_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: doc/cache_burst_ctrl.md
# cache_burst_ctrl

Parametrised N-way cache controller FSM with multi-beat line writeback and refill. Sits between the CPU request port and the tag/data/dirty/LRU arrays and drives the AXI-facing memory adapter. A beat counter sequences BEATS-word bursts with per-beat handshakes. The controller selects the victim way from LRU, raises dirty writeback before refill, and reports protocol errors.

## Interface
- WAYS, 4: associativity (power of 2, ≥2)
- BEATS, 8: words per line = beats per burst (power of 2, ≥2)
- CNT_W, 32: perf counter width (used only with CACHE_PERF_CNT_EN)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_valid  in  1  CPU request present; held until cpu_ready
- cpu_rw  in  1  1=write, 0=read; stable while cpu_valid
- cpu_ready  out  1  request accepted (pulse, LOOKUP hit or end of refill)
- resp_valid  out  1  read data valid on array read port (1 cycle)
- hit_miss  out  1  1 = accepted request hit
- match_way  in  WAYS  one-hot tag match (combinational from arrays)
- valid_way  in  WAYS  line valid bits of indexed set
- dirty_way  in  WAYS  dirty bits of indexed set
- lru_victim  in  $clog2(WAYS)  LRU-selected victim way
- way_sel  out  $clog2(WAYS)  way addressed by array controls
- beat_idx  out  $clog2(BEATS)  word within line for burst data
- tag_we, data_we, dirty_set, dirty_clr, lru_touch  out  1 each  array strobes for way_sel
- mem_avalid  out  1  burst address valid
- mem_aready  in  1  address accepted
- mem_rw  out  1  1=writeback, 0=refill; valid with mem_avalid
- mem_wvalid / mem_wready / mem_wlast  out / in / out  1  writeback data beat handshake
- mem_rvalid / mem_rready / mem_rlast  in / out / in  1  refill data beat handshake
- err  out  1  one-cycle pulse on refill rlast mismatch

## Operation
- States: IDLE, LOOKUP, WB_ADDR, WB_DATA, LD_ADDR, LD_DATA, DONE.
- IDLE: one cycle after reset, → LOOKUP.
- LOOKUP, cpu_valid=0: stay, all strobes 0.
- LOOKUP hit (|match_way): way_sel=encode(match_way); cpu_ready=1, hit_miss=1, lru_touch=1; write: data_we=1, dirty_set=1; read: resp_valid=1. Stay in LOOKUP.
- LOOKUP miss: way_sel=lru_victim latched into victim reg. Victim valid&dirty → WB_ADDR; else → LD_ADDR.
- WB_ADDR: mem_avalid=1, mem_rw=1; on mem_aready → WB_DATA, beat counter=0.
- WB_DATA: mem_wvalid=1, beat_idx=counter, mem_wlast=(counter==BEATS-1); counter increments on each mem_wvalid&mem_wready; last beat accepted → dirty_clr=1, → LD_ADDR.
- LD_ADDR: mem_avalid=1, mem_rw=0; on mem_aready → LD_DATA, counter=0.
- LD_DATA: mem_rready=1; each mem_rvalid beat: data_we=1, beat_idx=counter, counter++. On last beat (counter==BEATS-1): tag_we=1, → DONE.
- DONE: cpu_ready=1, hit_miss=0, lru_touch=1; write: data_we=1, dirty_set=1; read: resp_valid=1. → LOOKUP.
- Counter: $clog2(BEATS) bits, wraps to 0 after last beat; cleared on every address phase.

## Timing
- Reset: all outputs 0, state IDLE, counter 0, victim 0; reset mid-burst abandons burst in same edge, no further mem strobes.
- Hit latency: cpu_ready same cycle as cpu_valid in LOOKUP. Clean-miss latency: 1+(address wait)+BEATS+1 cycles minimum (≥BEATS+3).
- Dirty miss adds 1+BEATS cycles minimum.
- mem_avalid/mem_wvalid held until accepted; no deassert without handshake.
- rlast on non-final beat, or absent on final beat: err pulse on that beat; counter still governs completion.
- cpu_valid dropped mid-miss: miss completes; DONE still pulses cpu_ready (CPU must hold).

## Configuration
- CACHE_PERF_CNT_EN defined: adds outputs hit_cnt and miss_cnt (CNT_W each, reset 0, saturating at all-ones) incremented on LOOKUP hit accept and LOOKUP miss detect respectively.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset then read hit, match_way=4'b0100 → same cycle cpu_ready=1, hit_miss=1, resp_valid=1, way_sel=2, lru_touch=1.
- Clean read miss, lru_victim=1, valid_way=0, BEATS=8, aready/rvalid always 1 → 8 data_we pulses beat_idx 0..7, tag_we on beat 7, DONE cpu_ready with hit_miss=0 at cycle 11.
- Dirty write miss, victim 3 dirty, wready stalls every other cycle → 8 accepted beats with wlast only on 8th, dirty_clr once, then refill, DONE data_we+dirty_set.
- Refill with rlast on beat 5 → err pulse there, no early finish, tag_we on beat 7.
- rst asserted during WB_DATA beat 3 → next cycle all outputs 0, state IDLE, counter 0.
- CACHE_PERF_CNT_EN: 3 hits + 2 misses → hit_cnt=3, miss_cnt=2; with CNT_W=2, 5 hits → hit_cnt=3 (saturate).
